// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared instruction-field, NOP and fetch-state definitions
package cpu_pkg;

    localparam int unsigned COND_HI  = 31;
    localparam int unsigned COND_LO  = 28;
    localparam int unsigned OP_HI    = 27;
    localparam int unsigned OP_LO    = 26;
    localparam int unsigned FUNCT_HI = 25;
    localparam int unsigned FUNCT_LO = 20;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 12;

    // MOV r0,r0 with cond AL: decodes as an instruction that writes nothing useful
    localparam logic [31:0] CPU_NOP_WORD = 32'hE1A0_0000;

    localparam int unsigned PC_INC4 = 4;
    localparam int unsigned PC_INC8 = 8;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, instruction register and fetch/exec sequencing
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_WORD = CPU_NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              advance,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [3:0]        rd,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus8
);

    fetch_state_t      state;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pc_branch;
    logic              unused_target_lsbs;

    // Targets are word-aligned; the two low ALU result bits are dropped.
    assign pc_seq             = pc_q + ADDR_W'(PC_INC4);
    assign pc_branch          = {branch_target[ADDR_W-1:2], 2'b00};
    assign unused_target_lsbs = ^branch_target[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc_q  <= RESET_PC;
            ir    <= NOP_WORD;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (advance) begin
                        pc_q  <= pc_src ? pc_branch : pc_seq;
                        ir    <= NOP_WORD;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // Both handshake outputs decode straight from the single state flop.
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus8    = pc_q + ADDR_W'(PC_INC8);

    assign instr = ir;
    assign cond  = ir[COND_HI:COND_LO];
    assign op    = ir[OP_HI:OP_LO];
    assign funct = ir[FUNCT_HI:FUNCT_LO];
    assign rd    = ir[RD_HI:RD_LO];

endmodule
